// File: rtl/stego_pkg.sv
// rtl/stego_pkg.sv - shared constants, trit encoding and decoder state enum
// Purpose : common definitions for the stego encode/decode stages.
// Ports   : none (package).
// Config  : none here; see hidden_string_decoder.sv for HIDE_EARLY_STOP_EN.
package stego_pkg;

    localparam int IMG_DIM  = 64;
    localparam int BLK      = 4;
    localparam int TRITS    = 11;
    localparam int WORD_W   = 16;
    localparam int MSG_BITS = 4096;
    localparam int ACC_W    = 18;

    localparam logic [1:0] TRIT_ZERO  = 2'b00;
    localparam logic [1:0] TRIT_PLUS  = 2'b01;
    localparam logic [1:0] TRIT_MINUS = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_SAMPLE,
        ST_CONV,
        ST_STORE,
        ST_NEXT,
        ST_DONE
    } dec_state_e;

    // Maps an 8-bit modular green delta to {invalid, trit}.
    // Deltas other than 0, +1, -1 decode as zero and flag invalid.
    function automatic logic [2:0] delta_to_trit(input logic [7:0] delta);
        logic [2:0] r;
        case (delta)
            8'h00:   r = {1'b0, TRIT_ZERO};
            8'h01:   r = {1'b0, TRIT_PLUS};
            8'hFF:   r = {1'b0, TRIT_MINUS};
            default: r = {1'b1, TRIT_ZERO};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/base3_to_base2.sv
// rtl/base3_to_base2.sv - iterative base-3 to binary converter (Horner)
// Purpose : converts TRITS packed trits (2 bits each, trit 0 least significant)
//           into a WORD_W-bit word, one digit per cycle, most significant first.
// Ports   : clk, rst_n     - clock, async active-low reset
//           en             - one-cycle start pulse; trits must be stable
//           trits          - packed digits, trit j at trits[2j+:2]
//           value          - low WORD_W bits of the result
//           overflow       - result exceeded WORD_W bits
//           done           - one-cycle pulse, TRITS cycles after en
module base3_to_base2
    import stego_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [2*TRITS-1:0]   trits,
    output logic [WORD_W-1:0]    value,
    output logic                 overflow,
    output logic                 done
);

    logic [ACC_W-1:0] acc_q;
    logic [3:0]       idx_q;
    logic             run_q;
    logic             done_q;
    logic [1:0]       digit;

    assign digit    = trits[{idx_q, 1'b0} +: 2];
    assign value    = acc_q[WORD_W-1:0];
    assign overflow = |acc_q[ACC_W-1:WORD_W];
    assign done     = done_q;

    // The start cycle already folds in the top digit (0*3 + d[TRITS-1]),
    // so the remaining TRITS-1 digits follow on consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            idx_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (en) begin
            acc_q  <= {{(ACC_W-2){1'b0}}, trits[2*TRITS-1 -: 2]};
            idx_q  <= 4'(TRITS - 2);
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            acc_q  <= acc_q * ACC_W'(3) + {{(ACC_W-2){1'b0}}, digit};
            done_q <= (idx_q == 4'd0);
            run_q  <= (idx_q != 4'd0);
            if (idx_q != 4'd0) begin
                idx_q <= idx_q - 4'd1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

endmodule

// File: rtl/hidden_string_decoder.sv
// rtl/hidden_string_decoder.sv - recovers the hidden string from a stego image
// Purpose : scans the image in BLKxBLK blocks (column-fastest), reads green
//           deltas of pixels 1..TRITS against pixel 0 as trits and converts
//           each block's trits into one WORD_W-bit word of hidden_string.
// Config  : HIDE_EARLY_STOP_EN - a stored all-zero word ends decoding.
// Ports   : clk, rst_n       - clock, async active-low reset
//           start            - one-cycle pulse, accepted in IDLE/DONE only
//           in_pix           - pixel at [row,col], G in bits 15:8
//           row, col         - registered image read address
//           hidden_string    - recovered string, block b at [16b+:16]
//           busy             - decode in progress
//           decode_done      - held high after completion until next start
//           decode_err       - sticky invalid-delta / word-overflow flag
module hidden_string_decoder
    import stego_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [23:0]         in_pix,
    output logic [5:0]          row,
    output logic [5:0]          col,
    output logic [MSG_BITS-1:0] hidden_string,
    output logic                busy,
    output logic                decode_done,
    output logic                decode_err
);

    dec_state_e          state_q;
    logic [3:0]          n_q;
    logic [5:0]          blk_row_q;
    logic [5:0]          blk_col_q;
    logic [5:0]          row_q;
    logic [5:0]          col_q;
    logic [7:0]          base_q;
    logic [2*TRITS-1:0]  trit_q;
    logic                conv_en_q;
    logic [MSG_BITS-1:0] hidden_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic [7:0]          g_delta;
    logic [2:0]          dec;
    logic [4:0]          trit_pos;
    logic [11:0]         word_pos;
    logic                last_blk;
    logic [WORD_W-1:0]   conv_word;
    logic                conv_ovf;
    logic                conv_done;
    logic                unused_pix;

    assign g_delta    = in_pix[15:8] - base_q;
    assign dec        = delta_to_trit(g_delta);
    // Pixel n (1..TRITS) carries digit n-1.
    assign trit_pos   = {n_q - 4'd1, 1'b0};
    assign word_pos   = {blk_row_q[5:2], blk_col_q[5:2], 4'b0000};
    assign last_blk   = (blk_row_q == 6'(IMG_DIM - BLK)) && (blk_col_q == 6'(IMG_DIM - BLK));
    assign unused_pix = ^{in_pix[23:16], in_pix[7:0]};

    assign row           = row_q;
    assign col           = col_q;
    assign hidden_string = hidden_q;
    assign busy          = busy_q;
    assign decode_done   = done_q;
    assign decode_err    = err_q;

    base3_to_base2 u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (conv_en_q),
        .trits    (trit_q),
        .value    (conv_word),
        .overflow (conv_ovf),
        .done     (conv_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            blk_row_q <= '0;
            blk_col_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            base_q    <= '0;
            trit_q    <= '0;
            conv_en_q <= 1'b0;
            hidden_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            conv_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    hidden_q  <= '0;
                    err_q     <= 1'b0;
                    blk_row_q <= '0;
                    blk_col_q <= '0;
                    n_q       <= '0;
                    state_q   <= ST_FETCH;
                end
                ST_FETCH: begin
                    row_q   <= blk_row_q + {4'd0, n_q[3:2]};
                    col_q   <= blk_col_q + {4'd0, n_q[1:0]};
                    state_q <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (n_q == 4'd0) begin
                        base_q <= in_pix[15:8];
                    end else begin
                        trit_q[trit_pos +: 2] <= dec[1:0];
                        if (dec[2]) begin
                            err_q <= 1'b1;
                        end
                    end
                    if (n_q == 4'(TRITS)) begin
                        n_q       <= '0;
                        conv_en_q <= 1'b1;
                        state_q   <= ST_CONV;
                    end else begin
                        n_q     <= n_q + 4'd1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        state_q <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    hidden_q[word_pos +: WORD_W] <= conv_word;
                    if (conv_ovf) begin
                        err_q <= 1'b1;
                    end
`ifdef HIDE_EARLY_STOP_EN
                    // Two NUL characters terminate the message.
                    state_q <= (conv_word == '0) ? ST_DONE : ST_NEXT;
`else
                    state_q <= ST_NEXT;
`endif
                end
                ST_NEXT: begin
                    if (last_blk) begin
                        state_q <= ST_DONE;
                    end else begin
                        if (blk_col_q == 6'(IMG_DIM - BLK)) begin
                            blk_col_q <= '0;
                            blk_row_q <= blk_row_q + 6'(BLK);
                        end else begin
                            blk_col_q <= blk_col_q + 6'(BLK);
                        end
                        state_q <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CLEAR;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_string_decoder.sv
// tb/tb_hidden_string_decoder.sv - self-checking bench for hidden_string_decoder
module tb_hidden_string_decoder;
    import stego_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [23:0]         in_pix;
    logic [5:0]          row;
    logic [5:0]          col;
    logic [MSG_BITS-1:0] hidden_string;
    logic                busy;
    logic                decode_done;
    logic                decode_err;

    logic [7:0] img [0:4095];

    typedef struct packed {
        logic [MSG_BITS-1:0] str;
        logic                err;
        logic [31:0]         lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errs = 0;

    always #5 clk = ~clk;

    assign in_pix = {8'h00, img[{row, col}], 8'h00};

    hidden_string_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_pix        (in_pix),
        .row           (row),
        .col           (col),
        .hidden_string (hidden_string),
        .busy          (busy),
        .decode_done   (decode_done),
        .decode_err    (decode_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t        e;
        logic [7:0]  base;
        logic [7:0]  g;
        logic [7:0]  d;
        logic [31:0] acc;
        int          br;
        int          bc;
        int          n;
        e = '0;
        e.lat = 2 + 256 * 38;
        for (int b = 0; b < 256; b++) begin
            br = (b / 16) * 4;
            bc = (b % 16) * 4;
            base = img[br * 64 + bc];
            acc = 0;
            for (int j = 10; j >= 0; j--) begin
                n = j + 1;
                g = img[(br + n / 4) * 64 + bc + n % 4];
                d = g - base;
                if (d == 8'h01) acc = acc * 3 + 1;
                else if (d == 8'hFF) acc = acc * 3 + 2;
                else begin
                    acc = acc * 3;
                    if (d != 8'h00) e.err = 1'b1;
                end
            end
            if (acc > 65535) e.err = 1'b1;
            e.str[b * 16 +: 16] = acc[15:0];
`ifdef HIDE_EARLY_STOP_EN
            if (acc[15:0] == 16'h0000) begin
                e.lat = 1 + (b + 1) * 38;
                return e;
            end
`endif
        end
        return e;
    endfunction

    task automatic fill_all(input logic [7:0] g);
        for (int i = 0; i < 4096; i++) img[i] = g;
    endtask

    // Every block gets word 1 so none decodes to zero.
    task automatic fill_marked();
        fill_all(8'h80);
        for (int r = 0; r < 64; r += 4)
            for (int c = 1; c < 64; c += 4)
                img[r * 64 + c] = 8'h81;
    endtask

    task automatic fill_random();
        logic [7:0] base;
        int         idx;
        for (int b = 0; b < 256; b++) begin
            base = 8'($urandom);
            for (int n = 0; n < 16; n++) begin
                idx = ((b / 16) * 4 + n / 4) * 64 + (b % 16) * 4 + n % 4;
                if (n == 0) img[idx] = base;
                else if (n <= 11) begin
                    case ($urandom_range(0, 2))
                        0:       img[idx] = base;
                        1:       img[idx] = base + 8'd1;
                        default: img[idx] = base - 8'd1;
                    endcase
                end else img[idx] = 8'($urandom);
            end
        end
    endtask

    task automatic run_decode(input int poke_at);
        exp_t e;
        int   k;
        logic got;
        sb_q.push_back(model());
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_clear_on_start", decode_done, 0);
        k = 0;
        got = 1'b0;
        while (k < 20000 && !got) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            start = (k == poke_at);
            if (decode_done) got = 1'b1;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check("done_seen", got, 1);
        check("latency", k, e.lat);
        check("busy_at_done", busy, 0);
        check("decode_err", decode_err, e.err);
        for (int b = 0; b < 256; b++)
            check($sformatf("word%0d", b), hidden_string[b * 16 +: 16], e.str[b * 16 +: 16]);
        repeat (3) @(negedge clk);
        check("done_held", decode_done, 1);
    endtask

    initial begin
        fill_all(8'h80);
        repeat (3) @(negedge clk);
        check("rst_row", row, 0);
        check("rst_col", col, 0);
        check("rst_busy", busy, 0);
        check("rst_done", decode_done, 0);
        check("rst_err", decode_err, 0);
        check("rst_str", |hidden_string, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Block 0 digits d0=2, d2=1, d3=2 -> 65.
        fill_marked();
        img[1] = 8'h7F; img[2] = 8'h80; img[3] = 8'h81; img[64] = 8'h7F;
        run_decode(-1);
        check("w0_0041", hidden_string[15:0], 16'h0041);
        check("w0_noerr", decode_err, 0);

        // Invalid delta on block 0 pixel 1, all-minus block 5 overflows.
        img[1] = 8'h85;
        img[20] = 8'h00;
        for (int n = 1; n <= 11; n++) img[(n / 4) * 64 + 20 + n % 4] = 8'hFF;
        run_decode(-1);
        check("w0_baddelta", hidden_string[15:0], 16'h003F);
        check("w5_overflow", hidden_string[95:80], 16'hB3FA);
        check("err_set", decode_err, 1);

        // Flat image; error must clear on the new start.
        fill_all(8'h80);
        run_decode(-1);
        check("flat_noerr", decode_err, 0);

        // Random valid image; a start pulse mid-run must be ignored.
        fill_random();
        run_decode(500);

        // Abort inside block 100 with reset.
        fill_random();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 + 100 * 38 + 5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_row", row, 0);
        check("abort_col", col, 0);
        check("abort_busy", busy, 0);
        check("abort_done", decode_done, 0);
        check("abort_err", decode_err, 0);
        check("abort_str", |hidden_string, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", decode_done, 0);
        fill_random();
        run_decode(-1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
